// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and forwarding controller for a 5-stage F/D/X/M/W pipeline.
//   - D-stage and X-stage operand forwarding selects (youngest writer wins).
//   - Load-use and branch-after-load hazard detection (bubble into X).
//   - Whole-pipe freeze while a data memory access is outstanding.
//   - Sticky timeout error when a memory access hangs.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   : saturating stall counters on lu_stall_cnt / mem_stall_cnt
//   undefined : counter ports tied to zero, no counter flops
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   rs1_D/rs2_D, use_rs1_D/rs2_D    D-stage sources and their use flags
//   is_branch_D                     D-stage branch (reads rs1 in D)
//   rs1_X/rs2_X, alu_src_imm_X      X-stage sources, B operand is immediate
//   wr_en_X/M/W, wr_reg_X/M/W       per-stage destination write
//   mem_to_reg_X/M                  stage holds a load
//   mem_en_M, mem_ready             M-stage memory access and completion
//   stall_F/D/X/M, flush_X, bubble_W  pipeline control (combinational)
//   fwd_rs1_D/fwd_rs2_D             00 regfile, 01 X, 10 M, 11 W
//   fwd_A_X/fwd_B_X                 00 none, 01 M, 10 W
//   mem_timeout                     sticky hung-memory error (registered)
//   lu_stall_cnt, mem_stall_cnt     performance counters (registered)

module hazard_scoreboard #(
  parameter int unsigned REG_W       = 4,
  parameter int unsigned ZERO_REG    = 1,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic             is_branch_D,
  input  logic [REG_W-1:0] rs1_X,
  input  logic [REG_W-1:0] rs2_X,
  input  logic             alu_src_imm_X,
  input  logic             wr_en_X,
  input  logic             wr_en_M,
  input  logic             wr_en_W,
  input  logic [REG_W-1:0] wr_reg_X,
  input  logic [REG_W-1:0] wr_reg_M,
  input  logic [REG_W-1:0] wr_reg_W,
  input  logic             mem_to_reg_X,
  input  logic             mem_to_reg_M,
  input  logic             mem_en_M,
  input  logic             mem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_X,
  output logic             stall_M,
  output logic             flush_X,
  output logic             bubble_W,
  output logic [1:0]       fwd_rs1_D,
  output logic [1:0]       fwd_rs2_D,
  output logic [1:0]       fwd_A_X,
  output logic [1:0]       fwd_B_X,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] FWD_D_RF   = 2'b00;
  localparam logic [1:0] FWD_D_X    = 2'b01;
  localparam logic [1:0] FWD_D_M    = 2'b10;
  localparam logic [1:0] FWD_D_W    = 2'b11;
  localparam logic [1:0] FWD_X_NONE = 2'b00;
  localparam logic [1:0] FWD_X_M    = 2'b01;
  localparam logic [1:0] FWD_X_W    = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic lu_hz;
  logic br_hz;
  logic mem_stall;
  logic use1_D;

  // Writer in a stage matches a source; register 0 is never a real dependency when hardwired.
  function automatic logic src_match(input logic             wen,
                                     input logic [REG_W-1:0] wreg,
                                     input logic [REG_W-1:0] src);
    return wen && (wreg == src) && ((ZERO_REG == 0) || (src != '0));
  endfunction

  // D-stage select: the youngest matching writer decides; a load there yields
  // regfile because its data is not available to D (the hazard logic covers it).
  function automatic logic [1:0] fwd_d_sel(input logic [REG_W-1:0] src,
                                           input logic             wx,
                                           input logic [REG_W-1:0] rx,
                                           input logic             lx,
                                           input logic             wm,
                                           input logic [REG_W-1:0] rm,
                                           input logic             lm,
                                           input logic             ww,
                                           input logic [REG_W-1:0] rw);
    logic [1:0] sel;
    sel = FWD_D_RF;
    if (src_match(wx, rx, src)) begin
      sel = lx ? FWD_D_RF : FWD_D_X;
    end else if (src_match(wm, rm, src)) begin
      sel = lm ? FWD_D_RF : FWD_D_M;
    end else if (src_match(ww, rw, src)) begin
      sel = FWD_D_W;
    end
    return sel;
  endfunction

  // X-stage select: M is younger than W.
  function automatic logic [1:0] fwd_x_sel(input logic [REG_W-1:0] src,
                                           input logic             wm,
                                           input logic [REG_W-1:0] rm,
                                           input logic             ww,
                                           input logic [REG_W-1:0] rw);
    logic [1:0] sel;
    sel = FWD_X_NONE;
    if (src_match(wm, rm, src)) begin
      sel = FWD_X_M;
    end else if (src_match(ww, rw, src)) begin
      sel = FWD_X_W;
    end
    return sel;
  endfunction

  // Forwarding selects.
  always_comb begin
    fwd_rs1_D = fwd_d_sel(rs1_D, wr_en_X, wr_reg_X, mem_to_reg_X,
                          wr_en_M, wr_reg_M, mem_to_reg_M, wr_en_W, wr_reg_W);
    fwd_rs2_D = fwd_d_sel(rs2_D, wr_en_X, wr_reg_X, mem_to_reg_X,
                          wr_en_M, wr_reg_M, mem_to_reg_M, wr_en_W, wr_reg_W);
    fwd_A_X   = fwd_x_sel(rs1_X, wr_en_M, wr_reg_M, wr_en_W, wr_reg_W);
    fwd_B_X   = alu_src_imm_X ? FWD_X_NONE
                              : fwd_x_sel(rs2_X, wr_en_M, wr_reg_M, wr_en_W, wr_reg_W);
  end

  // Hazard detection; a branch reads rs1 in D even if use_rs1_D is low.
  always_comb begin
    use1_D    = use_rs1_D | is_branch_D;
    lu_hz     = mem_to_reg_X &
                ((use1_D    & src_match(wr_en_X, wr_reg_X, rs1_D)) |
                 (use_rs2_D & src_match(wr_en_X, wr_reg_X, rs2_D)));
    br_hz     = is_branch_D & mem_to_reg_M & src_match(wr_en_M, wr_reg_M, rs1_D);
    mem_stall = mem_en_M & ~mem_ready;
  end

  // Pipeline control: error freeze > memory freeze > hazard bubble.
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_X  = 1'b0;
    stall_M  = 1'b0;
    flush_X  = 1'b0;
    bubble_W = 1'b0;
    if ((state_q == ST_ERR) || mem_stall) begin
      stall_F  = 1'b1;
      stall_D  = 1'b1;
      stall_X  = 1'b1;
      stall_M  = 1'b1;
      bubble_W = 1'b1;
    end else if (lu_hz || br_hz) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_X = 1'b1;
    end
  end

  // Memory-wait FSM next state; the error is reached once the running count of
  // stalled cycles in this access reaches MEM_TIMEOUT-1 on a wait cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_stall) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d >= WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = ST_ERR;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
    mem_timeout_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;

  // Saturating stall counters.
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    ms_cnt_d = ms_cnt_q;
    if ((state_q == ST_RUN) && (lu_hz || br_hz) && !mem_stall && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
    if ((state_q != ST_RUN) && (ms_cnt_q != '1)) begin
      ms_cnt_d = ms_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt_q <= '0;
      ms_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end

  assign lu_stall_cnt  = lu_cnt_q;
  assign mem_stall_cnt = ms_cnt_q;
`else
  assign lu_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule
